// File: rtl/path_phase_sequencer_pkg.sv
// Shared definitions for the Path ORAM path-phase sequencer: state encoding,
// address-generator direction codes and the per-path beat count.
package path_phase_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_INIT_WAIT  = 3'd0,
      ST_FETCH_LEAF = 3'd1,
      ST_START_RD   = 3'd2,
      ST_WAIT_RD    = 3'd3,
      ST_START_WR   = 3'd4,
      ST_WAIT_WR    = 3'd5,
      ST_HALTED     = 3'd6
   } seq_state_t;

   localparam logic AGRW_READ  = 1'b1;
   localparam logic AGRW_WRITE = 1'b0;

   // A path spans every bucket from root to leaf, each bucket a fixed burst count.
   function automatic int path_beats(input int oraml, input int bkt_bursts);
      return (oraml + 1) * bkt_bursts;
   endfunction

endpackage

// File: rtl/path_beat_counter.sv
// Beat counter for one path phase; stops at PathBeats so that excess beats
// never wrap the count back into a legal-looking value.
module path_beat_counter #(
   parameter int PathBeats = 44,
   parameter int CntWidth  = $clog2(PathBeats + 1)
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Clear,
   input  logic                Enable,
   output logic [CntWidth-1:0] Count,
   output logic                Full
);

   localparam logic [CntWidth-1:0] MAX_COUNT = CntWidth'(PathBeats);

   logic [CntWidth-1:0] count_reg;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_reg <= '0;
      end else if (Clear) begin
         count_reg <= '0;
      end else if (Enable && (count_reg != MAX_COUNT)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign Count = count_reg;
   assign Full  = (count_reg == MAX_COUNT);

endmodule

// File: rtl/path_phase_sequencer.sv
// Top-level Path ORAM traffic controller: alternates a read path and a write
// path on one random leaf, stopping only between complete path pairs.
module path_phase_sequencer
   import path_phase_sequencer_pkg::*;
#(
   parameter int ORAML            = 10,
   parameter int BktSize_DRBursts = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InitDone,
   input  logic             Halt,
   input  logic [ORAML-1:0] LeafIn,
   input  logic             LeafInValid,
   output logic             LeafInReady,
   output logic             AGStart,
   input  logic             AGReady,
   output logic             AGRW,
   output logic [ORAML-1:0] AGLeaf,
   input  logic             ReadBeat,
   input  logic             WriteBeat,
   output logic             Reading,
   output logic             Writing,
   output logic             PairDone,
   output logic [31:0]      PathCount,
   output logic             Halted,
   output logic             ErrBeat
);

   localparam int PathBeats = path_beats(ORAML, BktSize_DRBursts);
   localparam int CntWidth  = $clog2(PathBeats + 1);
   localparam logic [CntWidth-1:0] PATH_BEATS_C = CntWidth'(PathBeats);

   seq_state_t          state_reg, state_next;
   logic [ORAML-1:0]    ag_leaf_reg;
   logic [31:0]         path_count_reg;
   logic                pair_done_reg, pair_done_next;
   logic                err_reg;
   logic                leaf_load, cnt_clear, cnt_en, cnt_full;
   logic                rd_phase, wr_phase, err_set;
   logic [CntWidth-1:0] beat_count;

   assign rd_phase = (state_reg == ST_START_RD) || (state_reg == ST_WAIT_RD);
   assign wr_phase = (state_reg == ST_START_WR) || (state_reg == ST_WAIT_WR);
   assign cnt_en   = (rd_phase && ReadBeat) || (wr_phase && WriteBeat);

   // Stray beats and beats beyond a full path are both protocol violations.
   assign err_set  = (ReadBeat && !rd_phase) || (WriteBeat && !wr_phase) ||
                     (cnt_en && cnt_full);

   path_beat_counter #(
      .PathBeats (PathBeats),
      .CntWidth  (CntWidth)
   ) u_cnt (
      .Clock  (Clock),
      .Reset  (Reset),
      .Clear  (cnt_clear),
      .Enable (cnt_en),
      .Count  (beat_count),
      .Full   (cnt_full)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg      <= ST_INIT_WAIT;
         ag_leaf_reg    <= '0;
         path_count_reg <= '0;
         pair_done_reg  <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pair_done_reg <= pair_done_next;
         err_reg       <= err_reg || err_set;
         if (leaf_load) begin
            ag_leaf_reg <= LeafIn;
         end
         if (pair_done_next) begin
            path_count_reg <= path_count_reg + 32'd1;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      leaf_load      = 1'b0;
      cnt_clear      = 1'b0;
      pair_done_next = 1'b0;
      LeafInReady    = 1'b0;
      AGStart        = 1'b0;
      AGRW           = AGRW_WRITE;
      Reading        = 1'b0;
      Writing        = 1'b0;
      Halted         = 1'b0;
      case (state_reg)
         ST_INIT_WAIT: begin
            if (InitDone) state_next = ST_FETCH_LEAF;
         end
         ST_FETCH_LEAF: begin
            // Halt wins so a pending leaf is left unconsumed.
            if (Halt) begin
               state_next = ST_HALTED;
            end else begin
               LeafInReady = 1'b1;
               if (LeafInValid) begin
                  leaf_load  = 1'b1;
                  cnt_clear  = 1'b1;
                  state_next = ST_START_RD;
               end
            end
         end
         ST_START_RD: begin
            AGStart = 1'b1;
            AGRW    = AGRW_READ;
            Reading = 1'b1;
            if (AGReady) state_next = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            Reading = 1'b1;
            if (beat_count == PATH_BEATS_C && AGReady) begin
               cnt_clear  = 1'b1;
               state_next = ST_START_WR;
            end
         end
         ST_START_WR: begin
            AGStart = 1'b1;
            AGRW    = AGRW_WRITE;
            Writing = 1'b1;
            if (AGReady) state_next = ST_WAIT_WR;
         end
         ST_WAIT_WR: begin
            Writing = 1'b1;
            if (beat_count == PATH_BEATS_C && AGReady) begin
               pair_done_next = 1'b1;
               state_next     = ST_FETCH_LEAF;
            end
         end
         ST_HALTED: begin
            Halted = 1'b1;
         end
         default: begin
            state_next = ST_INIT_WAIT;
         end
      endcase
   end

   assign AGLeaf    = ag_leaf_reg;
   assign PathCount = path_count_reg;
   assign PairDone  = pair_done_reg;
   assign ErrBeat   = err_reg;

endmodule

// File: tb/tb_path_phase_sequencer.sv
// Directed bench for path_phase_sequencer at ORAML=3, two bursts per bucket
// (8 beats per path).
module tb_path_phase_sequencer;

   localparam int ORAML = 3;
   localparam int BKT   = 2;
   localparam int PB    = 8;

   logic             Clock = 1'b0;
   logic             Reset, InitDone, Halt, LeafInValid, LeafInReady;
   logic [ORAML-1:0] LeafIn, AGLeaf;
   logic             AGStart, AGReady, AGRW, ReadBeat, WriteBeat;
   logic             Reading, Writing, PairDone, Halted, ErrBeat;
   logic [31:0]      PathCount;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   path_phase_sequencer #(.ORAML(ORAML), .BktSize_DRBursts(BKT)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .InitDone    (InitDone),
      .Halt        (Halt),
      .LeafIn      (LeafIn),
      .LeafInValid (LeafInValid),
      .LeafInReady (LeafInReady),
      .AGStart     (AGStart),
      .AGReady     (AGReady),
      .AGRW        (AGRW),
      .AGLeaf      (AGLeaf),
      .ReadBeat    (ReadBeat),
      .WriteBeat   (WriteBeat),
      .Reading     (Reading),
      .Writing     (Writing),
      .PairDone    (PairDone),
      .PathCount   (PathCount),
      .Halted      (Halted),
      .ErrBeat     (ErrBeat)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic reset_dut();
      InitDone = 0; Halt = 0; LeafIn = '0; LeafInValid = 0;
      AGReady = 0; ReadBeat = 0; WriteBeat = 0;
      Reset = 1;
      step();
      Reset = 0;
   endtask

   task automatic init_to_fetch();
      InitDone = 1;
      step();
      check("fetch_ready", {31'd0, LeafInReady}, 32'd1);
   endtask

   // From FETCH_LEAF: hand over a leaf and walk through START_RD into WAIT_RD.
   task automatic start_read(input logic [ORAML-1:0] leaf);
      LeafIn = leaf; LeafInValid = 1; AGReady = 1;
      step();
      LeafInValid = 0;
      check("startrd_agstart", {31'd0, AGStart}, 32'd1);
      check("startrd_agrw", {31'd0, AGRW}, 32'd1);
      check("startrd_reading", {31'd0, Reading}, 32'd1);
      check("startrd_leaf", {29'd0, AGLeaf}, {29'd0, leaf});
      step();
      check("waitrd_agstart", {31'd0, AGStart}, 32'd0);
   endtask

   task automatic read_beats(input int n);
      ReadBeat = 1;
      repeat (n) step();
      ReadBeat = 0;
   endtask

   task automatic write_beats(input int n);
      WriteBeat = 1;
      repeat (n) step();
      WriteBeat = 0;
   endtask

   initial begin
      Reset = 1;
      reset_dut();

      // Idle until InitDone.
      for (int i = 0; i < 5; i++) begin
         check("init_ready", {31'd0, LeafInReady}, 32'd0);
         check("init_agstart", {31'd0, AGStart}, 32'd0);
         step();
      end
      check("init_pathcount", PathCount, 32'd0);
      check("init_halted", {31'd0, Halted}, 32'd0);
      check("init_err", {31'd0, ErrBeat}, 32'd0);
      init_to_fetch();

      // Full pair on leaf 5, AGReady held low 20 cycles after the last read beat.
      start_read(3'd5);
      AGReady = 0;
      read_beats(PB);
      repeat (20) step();
      check("rdhold_reading", {31'd0, Reading}, 32'd1);
      check("rdhold_writing", {31'd0, Writing}, 32'd0);
      check("rdhold_agstart", {31'd0, AGStart}, 32'd0);
      AGReady = 1;
      step();
      check("startwr_agstart", {31'd0, AGStart}, 32'd1);
      check("startwr_agrw", {31'd0, AGRW}, 32'd0);
      check("startwr_writing", {31'd0, Writing}, 32'd1);
      check("startwr_reading", {31'd0, Reading}, 32'd0);
      check("startwr_leaf", {29'd0, AGLeaf}, 32'd5);
      step();
      check("waitwr_agstart", {31'd0, AGStart}, 32'd0);
      write_beats(PB);
      check("wr_full_nodone", {31'd0, PairDone}, 32'd0);
      step();
      check("pair_done", {31'd0, PairDone}, 32'd1);
      check("pair_count", PathCount, 32'd1);
      check("pair_fetch_ready", {31'd0, LeafInReady}, 32'd1);
      step();
      check("pair_done_pulse", {31'd0, PairDone}, 32'd0);
      check("pair_err", {31'd0, ErrBeat}, 32'd0);

      // Second pair, reset in WAIT_WR at count 3.
      start_read(3'd6);
      read_beats(PB);
      step();
      check("pair2_startwr", {31'd0, Writing}, 32'd1);
      step();
      write_beats(3);
      check("midwr_count", 32'(dut.beat_count), 32'd3);
      Reset = 1;
      step();
      Reset = 0;
      check("rst_writing", {31'd0, Writing}, 32'd0);
      check("rst_count", 32'(dut.beat_count), 32'd0);
      check("rst_pathcount", PathCount, 32'd0);
      check("rst_leaf", {29'd0, AGLeaf}, 32'd0);

      // Halt raised during WAIT_RD: the pair still completes, then halts.
      reset_dut();
      init_to_fetch();
      start_read(3'd3);
      Halt = 1;
      read_beats(PB);
      step();
      step();
      write_beats(PB);
      step();
      check("halt_pathcount", PathCount, 32'd1);
      check("halt_fetch_ready", {31'd0, LeafInReady}, 32'd0);
      check("halt_not_yet", {31'd0, Halted}, 32'd0);
      LeafInValid = 1;
      step();
      check("halted", {31'd0, Halted}, 32'd1);
      Halt = 0;
      repeat (3) step();
      check("halted_sticky", {31'd0, Halted}, 32'd1);
      check("halted_ready", {31'd0, LeafInReady}, 32'd0);
      check("halted_leaf", {29'd0, AGLeaf}, 32'd3);
      LeafInValid = 0;

      // Ninth read beat overflows a full path.
      reset_dut();
      init_to_fetch();
      start_read(3'd1);
      AGReady = 0;
      read_beats(PB);
      check("ovf_before", {31'd0, ErrBeat}, 32'd0);
      read_beats(1);
      check("ovf_err", {31'd0, ErrBeat}, 32'd1);
      check("ovf_count", 32'(dut.beat_count), 32'd8);
      check("ovf_reading", {31'd0, Reading}, 32'd1);
      repeat (3) step();
      check("ovf_sticky", {31'd0, ErrBeat}, 32'd1);
      reset_dut();
      check("ovf_rst_clear", {31'd0, ErrBeat}, 32'd0);

      // Write beat while still waiting for DRAM init.
      write_beats(1);
      check("stray_wr_err", {31'd0, ErrBeat}, 32'd1);
      check("stray_wr_ready", {31'd0, LeafInReady}, 32'd0);
      step();
      check("stray_wr_sticky", {31'd0, ErrBeat}, 32'd1);
      reset_dut();
      check("stray_rst_clear", {31'd0, ErrBeat}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
